// File: rtl/iob_ram_t2p_be.sv
// Two-port RAM (one write port, one read port) with byte strobes, 1/2-cycle read latency and post-reset zero sweep.
// Optional macro IOB_RAM_T2P_BE_FWD_EN: a same-address read/write returns merged (forwarded) data instead of the old word.
module iob_ram_t2p_be #(
    parameter              HEXFILE    = "none",
    parameter int unsigned ADDR_W     = 6,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned RD_LAT     = 1,
    parameter int unsigned INIT_CLEAR = 1
) (
    input  logic                clk_i,
    input  logic                arst_n_i,
    input  logic                w_en_i,
    input  logic [DATA_W/8-1:0] w_strb_i,
    input  logic [ADDR_W-1:0]   w_addr_i,
    input  logic [DATA_W-1:0]   w_data_i,
    input  logic                r_en_i,
    input  logic [ADDR_W-1:0]   r_addr_i,
    output logic [DATA_W-1:0]   r_data_o,
    output logic                r_valid_o,
    output logic                busy_o
);

    localparam int unsigned DEPTH  = 2 ** ADDR_W;
    localparam int unsigned STRB_W = DATA_W / 8;
    localparam bit          CLR_EN = (INIT_CLEAR == 1) && (HEXFILE == "none");

    if ((RD_LAT != 1) && (RD_LAT != 2)) begin : g_bad_rd_lat
        $error("iob_ram_t2p_be: RD_LAT must be 1 or 2");
    end
    if ((DATA_W % 8) != 0) begin : g_bad_data_w
        $error("iob_ram_t2p_be: DATA_W must be a multiple of 8");
    end

    typedef enum logic {
        S_CLEAR = 1'b0,
        S_READY = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [ADDR_W-1:0]   clr_addr_q, clr_addr_d;
    logic                busy_q, busy_d;
    logic                clr_we_c;
    logic                wr_en_c;
    logic                rd_en_c;
    logic [DATA_W-1:0]   rd_word_c;
    logic [DATA_W-1:0]   s1_data_q, s1_data_d;
    logic                s1_valid_q, s1_valid_d;
    logic [DATA_W-1:0]   mem [DEPTH];

    // Clear sweep sequencing and request gating
    always_comb begin
        state_d    = state_q;
        clr_addr_d = clr_addr_q;
        clr_we_c   = 1'b0;
        if (state_q == S_CLEAR) begin
            clr_we_c   = 1'b1;
            clr_addr_d = clr_addr_q + ADDR_W'(1);
            if (&clr_addr_q) begin
                state_d = S_READY;
            end
        end
        busy_d  = (state_d == S_CLEAR);
        wr_en_c = w_en_i && (state_q == S_READY);
        rd_en_c = r_en_i && (state_q == S_READY);
    end

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            state_q    <= CLR_EN ? S_CLEAR : S_READY;
            clr_addr_q <= '0;
            busy_q     <= CLR_EN;
        end else begin
            state_q    <= state_d;
            clr_addr_q <= clr_addr_d;
            busy_q     <= busy_d;
        end
    end

    // Storage array: sweep write has priority, otherwise byte-strobed user write
    always_ff @(posedge clk_i) begin
        if (clr_we_c) begin
            mem[clr_addr_q] <= '0;
        end else if (wr_en_c) begin
            for (int k = 0; k < STRB_W; k++) begin
                if (w_strb_i[k]) begin
                    mem[w_addr_i][8*k +: 8] <= w_data_i[8*k +: 8];
                end
            end
        end
    end

    // Read word; the default returns the pre-write content on a collision
    always_comb begin
        rd_word_c = mem[r_addr_i];
`ifdef IOB_RAM_T2P_BE_FWD_EN
        if (wr_en_c && (w_addr_i == r_addr_i)) begin
            for (int k = 0; k < STRB_W; k++) begin
                if (w_strb_i[k]) begin
                    rd_word_c[8*k +: 8] = w_data_i[8*k +: 8];
                end
            end
        end
`endif
        s1_valid_d = rd_en_c;
        s1_data_d  = rd_en_c ? rd_word_c : s1_data_q;
    end

    always_ff @(posedge clk_i or negedge arst_n_i) begin
        if (!arst_n_i) begin
            s1_data_q  <= '0;
            s1_valid_q <= 1'b0;
        end else begin
            s1_data_q  <= s1_data_d;
            s1_valid_q <= s1_valid_d;
        end
    end

    if (RD_LAT == 2) begin : g_lat2
        logic [DATA_W-1:0] s2_data_q, s2_data_d;
        logic              s2_valid_q, s2_valid_d;

        always_comb begin
            s2_valid_d = s1_valid_q;
            s2_data_d  = s1_valid_q ? s1_data_q : s2_data_q;
        end

        always_ff @(posedge clk_i or negedge arst_n_i) begin
            if (!arst_n_i) begin
                s2_data_q  <= '0;
                s2_valid_q <= 1'b0;
            end else begin
                s2_data_q  <= s2_data_d;
                s2_valid_q <= s2_valid_d;
            end
        end

        assign r_data_o  = s2_data_q;
        assign r_valid_o = s2_valid_q;
    end else begin : g_lat1
        assign r_data_o  = s1_data_q;
        assign r_valid_o = s1_valid_q;
    end

    assign busy_o = busy_q;

endmodule

// File: tb/tb_iob_ram_t2p_be.sv
// Bench for iob_ram_t2p_be: RD_LAT=1 and RD_LAT=2 instances share stimulus; a reference memory feeds per-instance scoreboards.
module tb_iob_ram_t2p_be;

    typedef struct {
        logic [31:0] d;
        int          due;
    } exp_t;

    logic        clk = 1'b0;
    logic        arst_n;
    logic        w_en;
    logic [3:0]  w_strb;
    logic [3:0]  w_addr;
    logic [31:0] w_data;
    logic        r_en;
    logic [3:0]  r_addr;
    logic [31:0] r_data1, r_data2;
    logic        r_valid1, r_valid2;
    logic        busy1, busy2;

    int          checks = 0;
    int          failures = 0;
    int          cyc = 0;
    logic [31:0] ref_mem [16];
    exp_t        q1[$];
    exp_t        q2[$];
    logic [31:0] last1 = '0;
    logic [31:0] last2 = '0;

    iob_ram_t2p_be #(.HEXFILE("none"), .ADDR_W(4), .DATA_W(32), .RD_LAT(1), .INIT_CLEAR(1)) u_lat1 (
        .clk_i(clk), .arst_n_i(arst_n), .w_en_i(w_en), .w_strb_i(w_strb), .w_addr_i(w_addr),
        .w_data_i(w_data), .r_en_i(r_en), .r_addr_i(r_addr), .r_data_o(r_data1),
        .r_valid_o(r_valid1), .busy_o(busy1)
    );

    iob_ram_t2p_be #(.HEXFILE("none"), .ADDR_W(4), .DATA_W(32), .RD_LAT(2), .INIT_CLEAR(1)) u_lat2 (
        .clk_i(clk), .arst_n_i(arst_n), .w_en_i(w_en), .w_strb_i(w_strb), .w_addr_i(w_addr),
        .w_data_i(w_data), .r_en_i(r_en), .r_addr_i(r_addr), .r_data_o(r_data2),
        .r_valid_o(r_valid2), .busy_o(busy2)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Output monitor, RD_LAT=1 instance
    always @(negedge clk) begin
        exp_t e;
        if (!arst_n) begin
            last1 = '0;
        end else if (r_valid1) begin
            if (q1.size() == 0) begin
                chk("lat1_unexpected_valid_qsize", 32'(q1.size()), 32'd1);
            end else begin
                e = q1.pop_front();
                chk("lat1_data", r_data1, e.d);
                chk("lat1_cycle", 32'(cyc), 32'(e.due));
                last1 = e.d;
            end
        end else begin
            chk("lat1_hold", r_data1, last1);
            if (q1.size() != 0 && q1[0].due <= cyc) begin
                chk("lat1_missing_valid", 32'(r_valid1), 32'd1);
                void'(q1.pop_front());
            end
        end
    end

    // Output monitor, RD_LAT=2 instance
    always @(negedge clk) begin
        exp_t e;
        if (!arst_n) begin
            last2 = '0;
        end else if (r_valid2) begin
            if (q2.size() == 0) begin
                chk("lat2_unexpected_valid_qsize", 32'(q2.size()), 32'd1);
            end else begin
                e = q2.pop_front();
                chk("lat2_data", r_data2, e.d);
                chk("lat2_cycle", 32'(cyc), 32'(e.due));
                last2 = e.d;
            end
        end else begin
            chk("lat2_hold", r_data2, last2);
            if (q2.size() != 0 && q2[0].due <= cyc) begin
                chk("lat2_missing_valid", 32'(r_valid2), 32'd1);
                void'(q2.pop_front());
            end
        end
    end

    // One READY-state cycle of stimulus; updates the reference and queues expected reads
    task automatic drive_cycle(input logic we, input logic [3:0] st, input logic [3:0] wa,
                               input logic [31:0] wd, input logic re, input logic [3:0] ra);
        logic [31:0] exp_w;
        exp_t        e;
        w_en = we; w_strb = st; w_addr = wa; w_data = wd; r_en = re; r_addr = ra;
        if (re) begin
            exp_w = ref_mem[ra];
`ifdef IOB_RAM_T2P_BE_FWD_EN
            if (we && wa == ra) begin
                for (int k = 0; k < 4; k++) if (st[k]) exp_w[8*k +: 8] = wd[8*k +: 8];
            end
`endif
            e.d = exp_w;
            e.due = cyc + 1;
            q1.push_back(e);
            e.due = cyc + 2;
            q2.push_back(e);
        end
        if (we) begin
            for (int k = 0; k < 4; k++) if (st[k]) ref_mem[wa][8*k +: 8] = wd[8*k +: 8];
        end
        @(negedge clk);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive_cycle(1'b0, 4'h0, 4'h0, 32'h0, 1'b0, 4'h0);
    endtask

    // Called right after reset release; checks busy over the whole sweep and optionally injects masked requests
    task automatic sweep_check(input int inject);
        chk("busy1_at_release", 32'(busy1), 32'd1);
        chk("busy2_at_release", 32'(busy2), 32'd1);
        for (int k = 1; k <= 16; k++) begin
            @(negedge clk);
            chk("busy1_sweep", 32'(busy1), 32'(k < 16));
            chk("busy2_sweep", 32'(busy2), 32'(k < 16));
            if (k == inject) begin
                w_en = 1'b1; w_strb = 4'hF; w_addr = 4'd2; w_data = 32'hDEADBEEF;
                r_en = 1'b1; r_addr = 4'd2;
            end else begin
                w_en = 1'b0; r_en = 1'b0;
            end
        end
        for (int a = 0; a < 16; a++) ref_mem[a] = '0;
    endtask

    task automatic read_all();
        for (int a = 0; a < 16; a++) drive_cycle(1'b0, 4'h0, 4'h0, 32'h0, 1'b1, 4'(a));
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    initial begin
        logic        we;
        logic [3:0]  wa, ra, st;
        logic [31:0] wd;
        arst_n = 1'b0;
        w_en = 1'b0; w_strb = '0; w_addr = '0; w_data = '0; r_en = 1'b0; r_addr = '0;
        repeat (2) @(negedge clk);
        chk("rst_busy1", 32'(busy1), 32'd1);
        chk("rst_busy2", 32'(busy2), 32'd1);
        chk("rst_valid1", 32'(r_valid1), 32'd0);
        chk("rst_valid2", 32'(r_valid2), 32'd0);
        chk("rst_data1", r_data1, 32'h0);
        chk("rst_data2", r_data2, 32'h0);

        #2 arst_n = 1'b1;
        sweep_check(-1);
        read_all();

        drive_cycle(1'b1, 4'b1111, 4'd3, 32'hAABBCCDD, 1'b0, 4'd0);
        drive_cycle(1'b1, 4'b0101, 4'd3, 32'h11223344, 1'b0, 4'd0);
        drive_cycle(1'b0, 4'b0000, 4'd0, 32'h0, 1'b1, 4'd3);
        drive_cycle(1'b1, 4'b0000, 4'd3, 32'hFFFFFFFF, 1'b0, 4'd0);
        drive_cycle(1'b0, 4'b0000, 4'd0, 32'h0, 1'b1, 4'd3);

        drive_cycle(1'b1, 4'b1111, 4'd1, 32'h1, 1'b0, 4'd0);
        drive_cycle(1'b1, 4'b1111, 4'd2, 32'h2, 1'b0, 4'd0);
        drive_cycle(1'b1, 4'b1111, 4'd3, 32'h3, 1'b0, 4'd0);
        drive_cycle(1'b0, 4'b0000, 4'd0, 32'h0, 1'b1, 4'd1);
        drive_cycle(1'b0, 4'b0000, 4'd0, 32'h0, 1'b1, 4'd2);
        drive_cycle(1'b0, 4'b0000, 4'd0, 32'h0, 1'b1, 4'd3);
        idle(2);

        drive_cycle(1'b1, 4'b0011, 4'd5, 32'hFFFFFFFF, 1'b1, 4'd5);
        drive_cycle(1'b0, 4'b0000, 4'd0, 32'h0, 1'b1, 4'd5);
        drive_cycle(1'b1, 4'b1111, 4'd6, 32'hCAFEF00D, 1'b1, 4'd1);
        drive_cycle(1'b0, 4'b0000, 4'd0, 32'h0, 1'b1, 4'd6);
        idle(1);

        for (int i = 0; i < 48; i++) begin
            we = 1'($urandom_range(0, 1));
            st = 4'($urandom);
            wa = 4'($urandom_range(0, 15));
            wd = $urandom;
            ra = (i % 3 == 0) ? wa : 4'($urandom_range(0, 15));
            drive_cycle(we, st, wa, wd, 1'($urandom_range(0, 1)), ra);
        end
        idle(3);

        #2 arst_n = 1'b0;
        @(negedge clk);
        chk("midrst_busy1", 32'(busy1), 32'd1);
        chk("midrst_busy2", 32'(busy2), 32'd1);
        #2 arst_n = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            @(negedge clk);
            chk("partial_busy1", 32'(busy1), 32'd1);
        end
        #2 arst_n = 1'b0;
        @(negedge clk);
        #2 arst_n = 1'b1;
        sweep_check(10);
        read_all();
        idle(4);

        chk("q1_drained", 32'(q1.size()), 32'd0);
        chk("q2_drained", 32'(q2.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
